// File: rtl/ps2_pkg.sv
// Shared types and frame helper for the PS/2 device-to-host transmitter.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BIT_HI,
    BIT_LO,
    GAP
  } ps2State_e;

  localparam int PS2_FRAME_BITS = 11;

  // Frame is sent LSB first: start(0), data[0..7], odd parity, stop(1).
  function automatic logic [PS2_FRAME_BITS-1:0] ps2Frame(input logic [7:0] data);
    return {1'b1, ~^data, data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_kbd_tx.sv
// Serialises scancode bytes into PS/2 device-to-host frames on idle-high clock/data lines.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int HALF_DIV = 2000,
  parameter int GAP_DIV  = 4000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy
);

  localparam logic [15:0] HALF_LAST = 16'(HALF_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_DIV - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

  ps2State_e                 state_q;
  logic [PS2_FRAME_BITS-1:0] shift_q;
  logic [3:0]                bitCnt_q;
  logic [15:0]               div_q;
  logic                      ps2Clk_q;
  logic                      ps2Data_q;
  logic                      ready_q;
  logic                      busy_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      div_q     <= '0;
      ps2Clk_q  <= 1'b1;
      ps2Data_q <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            shift_q   <= ps2Frame(tx_data);
            bitCnt_q  <= '0;
            div_q     <= '0;
            ps2Data_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= BIT_HI;
          end
        end
        BIT_HI: begin
          ps2Data_q <= shift_q[0];
          if (div_q == HALF_LAST) begin
            div_q    <= '0;
            ps2Clk_q <= 1'b0;
            state_q  <= BIT_LO;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        BIT_LO: begin
          if (div_q == HALF_LAST) begin
            div_q    <= '0;
            ps2Clk_q <= 1'b1;
            if (bitCnt_q == LAST_BIT) begin
              ps2Data_q <= 1'b1;
              state_q   <= GAP;
            end else begin
              // Next bit goes onto the line together with the rising clock.
              shift_q   <= shift_q >> 1;
              ps2Data_q <= shift_q[1];
              bitCnt_q  <= bitCnt_q + 4'd1;
              state_q   <= BIT_HI;
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        GAP: begin
          if (div_q == GAP_LAST) begin
            div_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign ps2_clk  = ps2Clk_q;
  assign ps2_data = ps2Data_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Scoreboard bench: a reference PS/2 receiver samples on falling ps2_clk and checks frames and bit timing.
module tb_ps2_kbd_tx;

  localparam int HALF      = 4;
  localparam int GAPC      = 6;
  localparam int FRAME_CYC = 22 * HALF + GAPC;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;
  int framesRx = 0;
  int framesExpected = 0;

  logic [7:0] expQ[$];
  int         accQ[$];

  ps2_kbd_tx #(.HALF_DIV(HALF), .GAP_DIV(GAPC)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Reference frame built bit by bit from the protocol rules.
  function automatic logic [10:0] refFrame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    f = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      if (b[i]) ones++;
    end
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Offers a byte and returns the cycle index of the accepting edge.
  task automatic applyStimulus(input logic [7:0] b, input bit keepValid, output int accCycle);
    int n;
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      checkOutput("acceptTimeout", 0, 1);
      tx_valid = 1'b0;
      accCycle = -1;
    end else begin
      expQ.push_back(b);
      framesExpected++;
      @(posedge clk);
      #1;
      accCycle = cycleCnt;
      accQ.push_back(accCycle);
      if (!keepValid) tx_valid = 1'b0;
    end
  endtask

  task automatic waitReady(input int acc, input string name, output int readyCyc);
    int n;
    n = 0;
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    readyCyc = cycleCnt;
    checkOutput(name, cycleCnt - acc, FRAME_CYC);
  endtask

  // Reference receiver: collects 11 samples per frame, abandons a partial frame on reset.
  initial begin
    logic [10:0] rx;
    int          fallAt[11];
    int          nb;
    int          badK;
    int          acc;
    logic [7:0]  expByte;
    rx = '0;
    nb = 0;
    forever begin
      @(negedge ps2_clk or negedge n_reset);
      if (!n_reset) begin
        nb = 0;
      end else begin
        rx[nb] = ps2_data;
        #1;
        fallAt[nb] = cycleCnt;
        nb++;
        if (nb == 11) begin
          nb = 0;
          framesRx++;
          if (expQ.size() == 0) begin
            checkOutput("unexpectedFrame", int'(rx), -1);
          end else begin
            expByte = expQ.pop_front();
            acc = accQ.pop_front();
            checkOutput("frame", int'(rx), int'(refFrame(expByte)));
            badK = -1;
            for (int k = 10; k >= 0; k--)
              if (fallAt[k] - acc != (2 * k + 1) * HALF) badK = k;
            checkOutput("fallTimingFirstBadBit", badK, -1);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a;
    int a2;
    int rc;
    int bad;
    int n;

    repeat (3) @(negedge clk);
    checkOutput("resetReady", int'(tx_ready), 1);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetPs2Clk", int'(ps2_clk), 1);
    checkOutput("resetPs2Data", int'(ps2_data), 1);
    n_reset = 1'b1;

    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0) bad++;
    end
    checkOutput("idleLines", bad, 0);

    @(negedge clk);
    applyStimulus(8'h1C, 1'b0, a);
    @(negedge clk);
    checkOutput("startBitAfterAccept", int'(ps2_data), 0);
    checkOutput("busyAfterAccept", int'(busy), 1);
    waitReady(a, "readyReturn1C", rc);

    // Back-to-back with tx_valid held across the first frame.
    applyStimulus(8'h00, 1'b1, a);
    tx_data = 8'hFF;
    @(negedge clk);
    waitReady(a, "b2bReady", rc);
    applyStimulus(8'hFF, 1'b0, a2);
    checkOutput("b2bAcceptOnFirstReady", a2 - rc, 1);
    @(negedge clk);
    waitReady(a2, "b2bReadySecond", rc);

    // Valid pulse during the low phase of bit 5 must be ignored.
    applyStimulus(8'hA5, 1'b0, a);
    repeat (45) @(negedge clk);
    checkOutput("bit5LowPhase", int'(ps2_clk), 0);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    waitReady(a, "readyAfterPulse", rc);

    // Scramble tx_data while the frame is in flight.
    applyStimulus(8'h5A, 1'b0, a);
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 400) begin
      tx_data = 8'($urandom);
      @(negedge clk);
      n++;
    end
    checkOutput("readyAfterScramble", cycleCnt - a, FRAME_CYC);

    // Reset in the middle of bit 4 aborts the frame.
    applyStimulus(8'hF0, 1'b0, a);
    repeat (34) @(negedge clk);
    n_reset = 1'b0;
    #1;
    checkOutput("abortPs2Clk", int'(ps2_clk), 1);
    checkOutput("abortPs2Data", int'(ps2_data), 1);
    checkOutput("abortReady", int'(tx_ready), 1);
    checkOutput("abortBusy", int'(busy), 0);
    framesExpected -= expQ.size();
    expQ.delete();
    accQ.delete();
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    applyStimulus(8'hF0, 1'b0, a);
    @(negedge clk);
    waitReady(a, "readyAfterAbort", rc);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      applyStimulus(8'($urandom), 1'b0, a);
      @(negedge clk);
      waitReady(a, "readyRandom", rc);
    end

    repeat (20) @(negedge clk);
    checkOutput("pendingFrames", expQ.size(), 0);
    checkOutput("frameCount", framesRx, framesExpected);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
